payout_sequencer: RTL and testbench



---
 rtl/vend_pkg.sv | 43 ++++
 rtl/payout_sequencer_timer.sv | 50 +++++
 rtl/payout_sequencer.sv | 263 ++++++++++++++++++++++++++
 tb/tb_payout_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared vending definitions: payout states, fault codes,
// coin values and the item-ordering helper.
package vend_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CANDY_DRV,
    ST_CANDY_WAIT,
    ST_OBEG_DRV,
    ST_OBEG_WAIT,
    ST_BEG_DRV,
    ST_BEG_WAIT,
    ST_DONE,
    ST_FAULT
  } pay_state_t;

  localparam logic [1:0] FC_NONE  = 2'd0;
  localparam logic [1:0] FC_CANDY = 2'd1;
  localparam logic [1:0] FC_OBEG  = 2'd2;
  localparam logic [1:0] FC_BEG   = 2'd3;

  localparam int BEG_VALUE  = 1;
  localparam int OBEG_VALUE = 5;

  // First channel still owed, in candy/obeg/beg order.
  function automatic pay_state_t first_item(
    input logic candy,
    input logic obeg,
    input logic beg_nz
  );
    pay_state_t s;
    if (candy)
      s = ST_CANDY_DRV;
    else if (obeg)
      s = ST_OBEG_DRV;
    else if (beg_nz)
      s = ST_BEG_DRV;
    else
      s = ST_DONE;
    return s;
  endfunction

endpackage

// File: rtl/payout_sequencer_timer.sv
// Shared drive-pulse and ack-timeout counters used by
// every payout channel, one item at a time.
module actuator_timer #(
  parameter int PULSE_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic wait_run,
  output logic pulse_active,
  output logic expired
);

  localparam int PW = $clog2(PULSE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [PW-1:0] P_LOAD =
    PW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] T_LAST =
    TW'(TIMEOUT_CYCLES - 1);

  logic [PW-1:0] pulse_cnt;
  logic [TW-1:0] wait_cnt;

  // Pulse counter: loaded on start, runs down to zero;
  // the drive lasts while it counts plus its zero cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pulse_cnt <= '0;
    else if (start)
      pulse_cnt <= P_LOAD;
    else if (pulse_cnt != '0)
      pulse_cnt <= pulse_cnt - 1'b1;
  end

  // Wait counter: held clear except while waiting for ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      wait_cnt <= '0;
    else if (start || !wait_run)
      wait_cnt <= '0;
    else if (wait_cnt != T_LAST)
      wait_cnt <= wait_cnt + 1'b1;
  end

  assign pulse_active = (pulse_cnt != '0);
  assign expired      = wait_run && (wait_cnt == T_LAST);

endmodule

// File: rtl/payout_sequencer.sv
// Payout sequencer: drives candy, obeg and beg actuators
// one item at a time with ack wait, retry and fault.
module payout_sequencer
  import vend_pkg::*;
#(
  parameter int PULSE_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int MAX_RETRY      = 2,
  parameter int CNT_W          = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             candy_req,
  input  logic [CNT_W-1:0] beg_n,
  input  logic             obeg_n,
  input  logic             candy_ack,
  input  logic             obeg_ack,
  input  logic             beg_ack,
  output logic             ready,
  output logic             candy_drv,
  output logic             obeg_drv,
  output logic             beg_drv,
  output logic             done,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] paid_beg,
  output logic             paid_obeg
);

  localparam int RW =
    (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] R_MAX = RW'(MAX_RETRY);

  pay_state_t state;
  pay_state_t state_d;

  logic             rem_candy;
  logic             rem_obeg;
  logic [CNT_W-1:0] rem_beg;
  logic [RW-1:0]    retry;
  logic             ack_pend;

  logic       accept;
  logic       complete;
  logic       retry_inc;
  logic       fault_set;
  logic [1:0] code_d;

  logic in_candy;
  logic in_obeg;
  logic in_beg;
  logic in_drv;
  logic in_wait;
  logic cur_ack;
  logic got_ack;
  logic can_retry;
  logic timer_start;
  logic pulse_active;
  logic expired;

  assign in_candy = (state == ST_CANDY_DRV) ||
                    (state == ST_CANDY_WAIT);
  assign in_obeg  = (state == ST_OBEG_DRV) ||
                    (state == ST_OBEG_WAIT);
  assign in_beg   = (state == ST_BEG_DRV) ||
                    (state == ST_BEG_WAIT);
  assign in_drv   = (state == ST_CANDY_DRV) ||
                    (state == ST_OBEG_DRV) ||
                    (state == ST_BEG_DRV);
  assign in_wait  = (state == ST_CANDY_WAIT) ||
                    (state == ST_OBEG_WAIT) ||
                    (state == ST_BEG_WAIT);

  // Only the ack of the channel being served is heard.
  always_comb begin
    cur_ack = 1'b0;
    unique case (1'b1)
      in_candy: cur_ack = candy_ack;
      in_obeg:  cur_ack = obeg_ack;
      in_beg:   cur_ack = beg_ack;
      default:  cur_ack = 1'b0;
    endcase
  end

  assign got_ack   = cur_ack || ack_pend;
  assign can_retry = (retry < R_MAX);

  // Next state and per-cycle control strobes.
  always_comb begin
    state_d   = state;
    accept    = 1'b0;
    complete  = 1'b0;
    retry_inc = 1'b0;
    fault_set = 1'b0;
    code_d    = FC_NONE;
    unique case (state)
      ST_IDLE: begin
        if (req) begin
          accept  = 1'b1;
          state_d = first_item(candy_req, obeg_n,
                               beg_n != '0);
        end
      end
      ST_CANDY_DRV: begin
        if (!pulse_active)
          state_d = ST_CANDY_WAIT;
      end
      ST_OBEG_DRV: begin
        if (!pulse_active)
          state_d = ST_OBEG_WAIT;
      end
      ST_BEG_DRV: begin
        if (!pulse_active)
          state_d = ST_BEG_WAIT;
      end
      ST_CANDY_WAIT: begin
        if (got_ack) begin
          complete = 1'b1;
          state_d  = first_item(1'b0, rem_obeg,
                                rem_beg != '0);
        end else if (expired) begin
          if (can_retry) begin
            retry_inc = 1'b1;
            state_d   = ST_CANDY_DRV;
          end else begin
            fault_set = 1'b1;
            code_d    = FC_CANDY;
            state_d   = ST_FAULT;
          end
        end
      end
      ST_OBEG_WAIT: begin
        if (got_ack) begin
          complete = 1'b1;
          state_d  = first_item(1'b0, 1'b0,
                                rem_beg != '0);
        end else if (expired) begin
          if (can_retry) begin
            retry_inc = 1'b1;
            state_d   = ST_OBEG_DRV;
          end else begin
            fault_set = 1'b1;
            code_d    = FC_OBEG;
            state_d   = ST_FAULT;
          end
        end
      end
      ST_BEG_WAIT: begin
        if (got_ack) begin
          complete = 1'b1;
          if (rem_beg > CNT_W'(1))
            state_d = ST_BEG_DRV;
          else
            state_d = ST_DONE;
        end else if (expired) begin
          if (can_retry) begin
            retry_inc = 1'b1;
            state_d   = ST_BEG_DRV;
          end else begin
            fault_set = 1'b1;
            code_d    = FC_BEG;
            state_d   = ST_FAULT;
          end
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_FAULT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // A drive pulse begins whenever a drive state is entered.
  assign timer_start =
    (state_d != state) &&
    ((state_d == ST_CANDY_DRV) ||
     (state_d == ST_OBEG_DRV) ||
     (state_d == ST_BEG_DRV));

  actuator_timer #(
    .PULSE_CYCLES   (PULSE_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk          (clk),
    .reset        (reset),
    .start        (timer_start),
    .wait_run     (in_wait),
    .pulse_active (pulse_active),
    .expired      (expired)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_d;
  end

  // Early ack seen mid-pulse, completed on the first wait cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ack_pend <= 1'b0;
    else if (timer_start || complete)
      ack_pend <= 1'b0;
    else if (in_drv && cur_ack)
      ack_pend <= 1'b1;
  end

  // Remaining items, paid counts, retries and sticky fault.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_candy  <= 1'b0;
      rem_obeg   <= 1'b0;
      rem_beg    <= '0;
      retry      <= '0;
      paid_beg   <= '0;
      paid_obeg  <= 1'b0;
      fault      <= 1'b0;
      fault_code <= FC_NONE;
    end else begin
      if (accept) begin
        rem_candy  <= candy_req;
        rem_obeg   <= obeg_n;
        rem_beg    <= beg_n;
        retry      <= '0;
        paid_beg   <= '0;
        paid_obeg  <= 1'b0;
        fault      <= 1'b0;
        fault_code <= FC_NONE;
      end
      if (complete) begin
        retry <= '0;
        unique case (1'b1)
          in_candy: rem_candy <= 1'b0;
          in_obeg: begin
            rem_obeg  <= 1'b0;
            paid_obeg <= 1'b1;
          end
          in_beg: begin
            if (rem_beg != '0)
              rem_beg <= rem_beg - 1'b1;
            paid_beg <= paid_beg + 1'b1;
          end
          default: ;
        endcase
      end else if (retry_inc) begin
        retry <= retry + 1'b1;
      end
      if (fault_set) begin
        fault      <= 1'b1;
        fault_code <= code_d;
      end
    end
  end

  assign ready     = (state == ST_IDLE);
  assign done      = (state == ST_DONE);
  assign candy_drv = (state == ST_CANDY_DRV);
  assign obeg_drv  = (state == ST_OBEG_DRV);
  assign beg_drv   = (state == ST_BEG_DRV);

endmodule

// File: tb/tb_payout_sequencer.sv
// Bench for payout_sequencer: table of payout transactions
// with an ack responder and scoreboard, plus hand sequences.
module tb_payout_sequencer;

  localparam int P  = 2;
  localparam int T  = 8;
  localparam int R  = 1;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          req;
  logic          candy_req;
  logic [CW-1:0] beg_n;
  logic          obeg_n;
  logic          candy_ack;
  logic          obeg_ack;
  logic          beg_ack;
  logic          ready;
  logic          candy_drv;
  logic          obeg_drv;
  logic          beg_drv;
  logic          done;
  logic          fault;
  logic [1:0]    fault_code;
  logic [CW-1:0] paid_beg;
  logic          paid_obeg;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic          candy;
    logic          obeg;
    logic [CW-1:0] beg;
    int            ack_at;
    logic [7:0]    mask;
    logic          stray;
    logic          busy_req;
    int            exp_pulses;
    logic          exp_fault;
    logic [1:0]    exp_code;
    logic [CW-1:0] exp_pbeg;
    logic          exp_pobeg;
    logic [15:0]   exp_order;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs[NV];
  vec_t sb[$];

  always #5 clk = ~clk;

  payout_sequencer #(
    .PULSE_CYCLES   (P),
    .TIMEOUT_CYCLES (T),
    .MAX_RETRY      (R),
    .CNT_W          (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .candy_req  (candy_req),
    .beg_n      (beg_n),
    .obeg_n     (obeg_n),
    .candy_ack  (candy_ack),
    .obeg_ack   (obeg_ack),
    .beg_ack    (beg_ack),
    .ready      (ready),
    .candy_drv  (candy_drv),
    .obeg_drv   (obeg_drv),
    .beg_drv    (beg_drv),
    .done       (done),
    .fault      (fault),
    .fault_code (fault_code),
    .paid_beg   (paid_beg),
    .paid_obeg  (paid_obeg)
  );

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic clear_in();
    req       = 1'b0;
    candy_req = 1'b0;
    obeg_n    = 1'b0;
    beg_n     = '0;
    candy_ack = 1'b0;
    obeg_ack  = 1'b0;
    beg_ack   = 1'b0;
  endtask

  task automatic set_ack(input logic [1:0] ch);
    if (ch == 2'd1) candy_ack = 1'b1;
    if (ch == 2'd2) obeg_ack  = 1'b1;
    if (ch == 2'd3) beg_ack   = 1'b1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          pulses;
    int          hi;
    int          wcnt;
    logic [1:0]  ch;
    logic [1:0]  last_ch;
    logic        acked;
    logic        ended;
    logic        width_ok;
    logic        onehot_ok;
    logic        first;
    logic [15:0] order;
    vec_t        e;
    pulses = 0; hi = 0; wcnt = 0;
    last_ch = 2'd0; acked = 1'b0; ended = 1'b0;
    width_ok = 1'b1; onehot_ok = 1'b1; order = '0;
    @(negedge clk);
    req       = 1'b1;
    candy_req = v.candy;
    obeg_n    = v.obeg;
    beg_n     = v.beg;
    sb.push_back(v);
    @(negedge clk);
    for (int c = 0; c < 400 && !ended; c++) begin
      clear_in();
      if (c == 0) begin
        first = (v.exp_pulses > 0) ?
          (candy_drv | obeg_drv | beg_drv) : done;
        check($sformatf("v%0d_latency", idx), first, 1);
        check($sformatf("v%0d_fault_clr", idx), fault, 0);
      end
      if (done || fault) begin
        ended = 1'b1;
      end else begin
        if (32'(candy_drv) + 32'(obeg_drv) +
            32'(beg_drv) > 1)
          onehot_ok = 1'b0;
        ch = candy_drv ? 2'd1 :
             obeg_drv  ? 2'd2 :
             beg_drv   ? 2'd3 : 2'd0;
        if (ch != 2'd0) begin
          if (hi == 0) begin
            pulses++;
            if (pulses <= 8)
              order[(pulses-1)*2 +: 2] = ch;
            last_ch = ch;
            acked   = 1'b0;
            wcnt    = 0;
          end
          hi++;
          if (v.ack_at < 0 && hi == 1 && pulses <= 8 &&
              v.mask[pulses-1] && !acked) begin
            set_ack(ch);
            acked = 1'b1;
          end
        end else begin
          if (hi != 0) begin
            if (hi != P) width_ok = 1'b0;
            hi = 0;
          end
          if (last_ch != 2'd0 && !acked) begin
            if (wcnt == v.ack_at && pulses <= 8 &&
                v.mask[pulses-1]) begin
              set_ack(last_ch);
              acked = 1'b1;
            end
            if (v.stray && last_ch == 2'd1 && wcnt == 1) begin
              beg_ack  = 1'b1;
              obeg_ack = 1'b1;
            end
            if (v.busy_req && pulses == 1 && wcnt == 0) begin
              req       = 1'b1;
              candy_req = 1'b1;
              obeg_n    = 1'b1;
              beg_n     = 3'd7;
            end
          end
          wcnt++;
        end
        @(negedge clk);
      end
    end
    e = sb.pop_front();
    check($sformatf("v%0d_finished", idx), ended, 1);
    if (ended) begin
      check($sformatf("v%0d_fault", idx), fault, e.exp_fault);
      check($sformatf("v%0d_done", idx), done, !e.exp_fault);
      check($sformatf("v%0d_code", idx), fault_code, e.exp_code);
      check($sformatf("v%0d_paid_beg", idx), paid_beg, e.exp_pbeg);
      check($sformatf("v%0d_paid_obeg", idx), paid_obeg,
            e.exp_pobeg);
      check($sformatf("v%0d_pulses", idx), pulses, e.exp_pulses);
      check($sformatf("v%0d_order", idx), order, e.exp_order);
      check($sformatf("v%0d_width", idx), width_ok, 1);
      check($sformatf("v%0d_onehot", idx), onehot_ok, 1);
      @(negedge clk);
      check($sformatf("v%0d_ready_after", idx), ready, 1);
      check($sformatf("v%0d_done_once", idx), done, 0);
    end
  endtask

  task automatic reset_midop();
    logic hi_seen;
    logic hit;
    int   falls;
    hi_seen = 1'b0; hit = 1'b0; falls = 0;
    @(negedge clk);
    req   = 1'b1;
    beg_n = 3'd3;
    @(negedge clk);
    for (int c = 0; c < 60 && !hit; c++) begin
      clear_in();
      if (beg_drv) begin
        if (falls == 1) hit = 1'b1;
        else hi_seen = 1'b1;
      end else if (hi_seen) begin
        falls++;
        hi_seen = 1'b0;
        if (falls == 1) beg_ack = 1'b1;
      end
      if (!hit) @(negedge clk);
    end
    check("rst_reached_beg", hit, 1);
    if (hit) begin
      check("rst_pre_paid", paid_beg, 1);
      reset = 1'b1;
      #1;
      check("rst_async_drop", beg_drv, 0);
      check("rst_async_ready", ready, 1);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_post_ready", ready, 1);
      check("rst_post_paid", paid_beg, 0);
      check("rst_post_done", done, 0);
      check("rst_post_drv",
            {candy_drv, obeg_drv, beg_drv}, 0);
    end
  endtask

  initial begin
    //            c     o     beg  at  mask   st    bz    n  flt   code  pb    po    order
    vecs[0]  = '{1'b1, 1'b1, 3'd2, 3, 8'hFF, 1'b0, 1'b0, 4, 1'b0, 2'd0, 3'd2, 1'b1, 16'h00F9};
    vecs[1]  = '{1'b0, 1'b0, 3'd0, 3, 8'hFF, 1'b0, 1'b0, 0, 1'b0, 2'd0, 3'd0, 1'b0, 16'h0000};
    vecs[2]  = '{1'b0, 1'b0, 3'd1, 3, 8'hFE, 1'b0, 1'b0, 2, 1'b0, 2'd0, 3'd1, 1'b0, 16'h000F};
    vecs[3]  = '{1'b0, 1'b1, 3'd0, 3, 8'h00, 1'b0, 1'b0, 2, 1'b1, 2'd2, 3'd0, 1'b0, 16'h000A};
    vecs[4]  = '{1'b1, 1'b0, 3'd0, 3, 8'h00, 1'b0, 1'b0, 2, 1'b1, 2'd1, 3'd0, 1'b0, 16'h0005};
    vecs[5]  = '{1'b0, 1'b0, 3'd3, 3, 8'hFE, 1'b0, 1'b0, 4, 1'b0, 2'd0, 3'd3, 1'b0, 16'h00FF};
    vecs[6]  = '{1'b0, 1'b0, 3'd7, 0, 8'hFF, 1'b0, 1'b0, 7, 1'b0, 2'd0, 3'd7, 1'b0, 16'h3FFF};
    vecs[7]  = '{1'b0, 1'b0, 3'd2, 3, 8'h01, 1'b0, 1'b0, 3, 1'b1, 2'd3, 3'd1, 1'b0, 16'h003F};
    vecs[8]  = '{1'b1, 1'b1, 3'd1, -1, 8'hFF, 1'b0, 1'b0, 3, 1'b0, 2'd0, 3'd1, 1'b1, 16'h0039};
    vecs[9]  = '{1'b0, 1'b0, 3'd1, 7, 8'hFF, 1'b0, 1'b0, 1, 1'b0, 2'd0, 3'd1, 1'b0, 16'h0003};
    vecs[10] = '{1'b1, 1'b0, 3'd1, 3, 8'hFF, 1'b1, 1'b1, 2, 1'b0, 2'd0, 3'd1, 1'b0, 16'h000D};

    clear_in();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset_ready", ready, 1);
    check("reset_drv", {candy_drv, obeg_drv, beg_drv}, 0);
    check("reset_done_fault", {done, fault}, 0);
    check("reset_code", fault_code, 0);
    check("reset_paid", {paid_beg, paid_obeg}, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++)
      run_vec(i, vecs[i]);

    @(negedge clk);
    candy_ack = 1'b1;
    obeg_ack  = 1'b1;
    beg_ack   = 1'b1;
    @(negedge clk);
    clear_in();
    @(negedge clk);
    check("idle_ack_paid_beg", paid_beg, 1);
    check("idle_ack_paid_obeg", paid_obeg, 0);
    check("idle_ack_ready", ready, 1);
    check("idle_ack_drv", {candy_drv, obeg_drv, beg_drv}, 0);

    reset_midop();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
